bpf_stream_ctrl: RTL
====================

Name: bpf_stream_ctrl

Overview:
Sequencer for the 16-phase time-multiplexed bandpass filter. It accepts an 18-bit sample stream over a valid/ready interface into a small FIFO and drives the filter's clock-enable and sample input. It mirrors the filter's internal 16-phase counter so each sample is applied exactly on the load phase. It returns the filter results as a valid-strobed output stream and keeps an underrun statistic. It sits between the ADC/decimator front end and the downstream sink, one instance per filter.

Parameters:
FIFO_DEPTH, 4, input FIFO depth in samples; power of two, 2..16.
PHASES, 16, filter frame length in clocks; fixed at 16 for the current filter.
CNT_W, 16, width of the saturating underrun counter.

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_enable  in  1  run request; sampled at phase 15 only
i_s_valid  in  1  input sample valid
i_s_data  in  18  input sample, signed two's complement
o_s_ready  out  1  FIFO not full
o_filt_clk_en  out  1  to filter i_clk_en
o_filt_data  out  18  to filter i_data
i_filt_out  in  18  from filter o_data
o_m_valid  out  1  one-cycle result strobe
o_m_data  out  18  filter result, signed
o_fill  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
o_running  out  1  state==RUN
o_underrun_cnt  out  CNT_W  saturating count of zero-filled frames

Behaviour:
- One clock. Reset is asynchronous and active-low (i_rst_n); the clock is i_clk. The filter shares the same reset.
- Reset values: state=START, phase=0, FIFO empty, o_s_ready=1, o_m_valid=0, o_m_data=0, o_fill=0, o_underrun_cnt=0, o_running=0, live flags=0.
- The phase counter (4 bits) increments modulo 16 on every edge where o_filt_clk_en=1. It tracks the filter counter exactly.
- The filter cannot be stalled at phases 0-14 because it accumulates every clock. It may only be held at phase 15, where its accumulator is cleared each cycle.
- FSM:
  - START: o_filt_clk_en=1 while phase!=15. At phase 15 it drives clk_en=0 and moves to IDLE. Flushes the post-reset frame; no output is emitted.
  - IDLE: held at phase 15. o_filt_clk_en=i_enable. If i_enable=1, the load occurs this cycle (see Load) and the FSM moves to RUN.
  - RUN: o_filt_clk_en=1 for phases 0-14. At phase 15, o_filt_clk_en=i_enable. If i_enable=1, the load occurs. If i_enable=0, the FSM moves to IDLE with no pop and no underrun.
- Load (phase 15, o_filt_clk_en=1):
  - If the FIFO is non-empty: o_filt_data=FIFO head (combinational from FIFO storage) and pop.
  - If the FIFO is empty: o_filt_data=0 and o_underrun_cnt increments, saturating at all-ones.
  - o_filt_data=0 in all other cycles.
- Result path:
  - A load at edge E0 sets live0. At the next phase-15 edge (E16) the filter writes the result, live0 moves to live1, and live0 is reloaded by any load at the same edge.
  - At E17, if live1=1: o_m_data<=i_filt_out, o_m_valid<=1 for one cycle, and live1 clears.
  - Latency from pop edge to o_m_valid high is 17 cycles. The throughput is one result per 16 cycles in RUN.
  - A frame in progress when RUN exits to IDLE still produces its result.
- o_m_data holds its value between strobes. There is no backpressure on the output; the sink must accept every strobe.
- FIFO behaviour:
  - Push when i_s_valid && o_s_ready, with o_s_ready=!full. Samples offered while full are not accepted; the source holds them.
  - A push and a pop in the same cycle are both performed; o_fill is unchanged.
  - A push into an empty FIFO at the load cycle is not bypassed: that frame is zero-filled and the pushed sample is used next frame.
  - Pointers wrap modulo FIFO_DEPTH. o_fill is registered.
- FIFO contents are retained across IDLE. Only reset clears them.
- Reset asserted mid-frame: all state returns to its reset value immediately. Pending results are discarded. START runs again after release.
- Output arithmetic: no modification; o_m_data is the filter's rounded and saturated value passed through unchanged.

Test Plan:
1. Reset release, i_enable=0 -> o_filt_clk_en high for 15 cycles, then low; o_m_valid never asserts; o_running=0.
2. i_enable=1, single impulse sample 18'h01000 followed by zeros -> first o_m_valid exactly 17 cycles after pop, then one strobe every 16 cycles. Data must match the filter golden model. o_underrun_cnt=0.
3. RUN with source idle (i_s_valid=0) for 5 frames -> o_underrun_cnt=5, o_filt_data=0 at each load, and 5 o_m_valid strobes still occur.
4. Burst of 6 samples with FIFO_DEPTH=4 -> o_s_ready drops after 4 accepted, and o_fill=4. Pops happen at phase 15, one per 16 cycles. All 6 samples are applied in order with no loss.
5. Deassert i_enable mid-frame (phase 7) -> clk_en stays high through phase 14 and is low at phase 15. The last result still strobes at +17; o_running=0. FIFO retains the remaining samples; re-enable resumes from the FIFO head.
6. Pulse i_rst_n low at phase 9 with 2 samples queued and a result pending -> outputs are at reset values immediately, o_fill=0, no stale o_m_valid, and the START sequence repeats.

Source files
------------

// File: rtl/bpf_stream_ctrl.sv
// Stream sequencer for the 16-phase time-multiplexed bandpass filter: input FIFO,
// phase-locked sample loading, result strobing and underrun statistics.
module bpf_stream_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int PHASES     = 16,
  parameter int CNT_W      = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_enable,
  input  logic                          i_s_valid,
  input  logic [17:0]                   i_s_data,
  output logic                          o_s_ready,
  output logic                          o_filt_clk_en,
  output logic [17:0]                   o_filt_data,
  input  logic [17:0]                   i_filt_out,
  output logic                          o_m_valid,
  output logic [17:0]                   o_m_data,
  output logic [$clog2(FIFO_DEPTH):0]   o_fill,
  output logic                          o_running,
  output logic [CNT_W-1:0]              o_underrun_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;
  localparam int PW = $clog2(PHASES);
  localparam logic [PW-1:0] LAST_PH = PW'(PHASES - 1);

  typedef enum logic [1:0] {START, IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   phase;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [17:0]     mem [FIFO_DEPTH];
  logic            at_last, load, pop, push, empty, full;
  logic            live0, live1;

  assign at_last   = (phase == LAST_PH);
  assign empty     = (o_fill == '0);
  assign full      = (o_fill == FW'(FIFO_DEPTH));
  assign o_s_ready = !full;
  assign push      = i_s_valid && !full;
  assign pop       = load && !empty;
  // Head is presented combinationally so the filter latches it on the load edge.
  assign o_filt_data = pop ? mem[rd_ptr] : '0;
  assign o_running   = (state == RUN);

  // The filter accumulates every clock, so it may only be held at the last phase.
  always_comb begin
    state_nxt     = state;
    o_filt_clk_en = 1'b1;
    load          = 1'b0;
    case (state)
      START: if (at_last) begin
        o_filt_clk_en = 1'b0;
        state_nxt     = IDLE;
      end
      IDLE: begin
        o_filt_clk_en = i_enable;
        load          = i_enable;
        if (i_enable) state_nxt = RUN;
      end
      RUN: if (at_last) begin
        o_filt_clk_en = i_enable;
        load          = i_enable;
        if (!i_enable) state_nxt = IDLE;
      end
      default: state_nxt = START;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_s_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= START;
      phase          <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      o_fill         <= '0;
      o_underrun_cnt <= '0;
      live0          <= 1'b0;
      live1          <= 1'b0;
      o_m_valid      <= 1'b0;
      o_m_data       <= '0;
    end else begin
      state <= state_nxt;
      if (o_filt_clk_en) phase <= phase + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push != pop) o_fill <= push ? o_fill + 1'b1 : o_fill - 1'b1;
      if (load && empty && !(&o_underrun_cnt)) o_underrun_cnt <= o_underrun_cnt + 1'b1;
      // Frame result is written by the filter at the next last-phase edge even if
      // the run was dropped there; it is captured one clock later.
      if (at_last) live0 <= load;
      live1     <= at_last && live0;
      o_m_valid <= live1;
      if (live1) o_m_data <= i_filt_out;
    end
  end

endmodule
